pong_game_state: RTL and testbench
==================================

PONG_GAME_STATE -- requirements
Module: pong_game_state

Interface
REQ-001 SHALL have parameter H_RES, default 640, visible width in pixels.
REQ-002 SHALL have parameter V_RES, default 480, visible height in lines.
REQ-003 SHALL have parameter PADDLE_H, default 64, paddle height in lines.
REQ-004 SHALL have parameter PADDLE_STEP, default 4, paddle move per frame in lines.
REQ-005 SHALL have parameter BALL_SIZE, default 8, square ball edge in pixels.
REQ-006 SHALL have parameter SCORE_MAX, default 9, winning score.
REQ-007 SHALL have port clk, input, 1, the single clock.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port frame_tick, input, 1, one-cycle pulse at start of vertical blank.
REQ-010 SHALL have ports left_up, left_down, right_up and right_down, input, 1 each, synchronized active-high buttons.
REQ-011 SHALL have port score_reset, input, 1, synchronized active-high level.
REQ-012 SHALL have port speed_sel, input, 2, ball speed select.
REQ-013 SHALL have ports lpad_y and rpad_y, output, 9 each, paddle top line.
REQ-014 SHALL have ports ball_x, output, 10, and ball_y, output, 9, ball top-left corner.
REQ-015 SHALL have ports score_l and score_r, output, 4 each, binary scores.
REQ-016 SHALL have port game_over, output, 1, high in state OVER.

Function
REQ-017 SHALL change state and outputs only in the cycle after a frame_tick, except on reset and score_reset.
REQ-018 SHALL register all outputs, with no combinational path from inputs to outputs.
REQ-019 SHALL implement states SERVE, PLAY, POINT and OVER.
REQ-020 SHALL, in SERVE, hold the ball at ((H_RES-BALL_SIZE)/2, (V_RES-BALL_SIZE)/2) for 60 frames, then enter PLAY.
REQ-021 SHALL, in PLAY, add dx and dy to the ball every frame, where |dx| = |dy| = speed_sel+1 pixels.
REQ-022 SHALL, in PLAY, negate dy when the ball reaches the top or bottom edge and clamp it to range 0..V_RES-BALL_SIZE in that same frame.
REQ-023 SHALL treat the left paddle as occupying x 16..23 and the right paddle as x H_RES-24..H_RES-17.
REQ-024 SHALL, on a left-paddle hit, set dx positive and snap ball_x to 24.
REQ-025 SHALL define a left-paddle hit as dx<0, ball_x<=24 and ball/paddle vertical overlap of at least one line; the right paddle is mirrored.
REQ-026 SHALL, when a moving-left ball reaches ball_x<=0, increment score_r and enter POINT; the mirrored case at the right edge increments score_l.
REQ-027 SHALL hold the ball frozen in POINT for 30 frames, then enter OVER if either score equals SCORE_MAX, else enter SERVE.
REQ-028 SHALL serve toward the player who lost the last point, and toward the right after reset.
REQ-029 SHALL move each paddle by PADDLE_STEP per frame in every state except OVER.
REQ-030 SHALL apply no paddle move when both buttons of a pair are high.
REQ-031 SHALL clamp each paddle to range 0..V_RES-PADDLE_H with no wrap-around.
REQ-032 SHALL keep OVER until score_reset, freezing all positions.
REQ-033 SHALL, on score_reset high in any state, set both scores to 0, enter SERVE, centre the ball and clear the frame counter on the next clock edge, independent of frame_tick.
REQ-034 SHALL give score_reset priority over a simultaneous point.

Reset
REQ-035 SHALL, while rst_n is low, set state SERVE, both paddles to (V_RES-PADDLE_H)/2, the ball to centre, scores 0, game_over 0, frame counter 0 and serve direction right.
REQ-036 SHALL, on reset mid-game, abandon all motion and counters immediately, and the first frame_tick after release counts as SERVE frame 1.

Configuration
REQ-037 SHALL, with macro PONG_SPEED_SEL_EN defined, use speed_sel as in REQ-021, sampled only on entry to PLAY.
REQ-038 SHALL, without PONG_SPEED_SEL_EN, use a fixed speed of 2 pixels per frame and leave speed_sel unused, but keep the port.

Structure
REQ-039 SHALL place the state enum, paddle x constants and serve/point frame counts (60, 30) in a shared package, pong_pkg, also used by the renderer.
REQ-040 SHALL implement paddle move-and-clamp as sub-module pong_paddle, instantiated twice.

Verification
REQ-041 SHALL cover: reset, then 60 frame_ticks -> state PLAY, ball at (316,236) moving +x.
REQ-042 SHALL cover: left_up held for 100 frames from reset -> lpad_y 208 decreasing by 4 per frame to 0, then stays 0.
REQ-043 SHALL cover: left_up and left_down both held -> lpad_y unchanged.
REQ-044 SHALL cover: ball driven to right edge with rpad_y far away -> score_l 1, 30 frozen frames, then SERVE toward the right player.
REQ-045 SHALL cover: score_l reaching 9 -> game_over 1 after the POINT hold; score_reset -> scores 0, game_over 0 next cycle.
REQ-046 SHALL cover: ball at top with dy negative and speed_sel=3 -> ball_y clamped to 0, dy +4 next frame.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared game-state encoding, paddle x geometry and
// serve/point hold lengths for the game core and the renderer.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_SERVE,
        ST_PLAY,
        ST_POINT,
        ST_OVER
    } state_e;

    // Left paddle columns; the right paddle mirrors them.
    localparam int LPAD_X_LO = 16;
    localparam int LPAD_X_HI = 23;
    localparam int PAD_W     = LPAD_X_HI - LPAD_X_LO + 1;

    localparam int SERVE_FRAMES = 60;
    localparam int POINT_FRAMES = 30;
    localparam int FCNT_W       = 6;

    // First column of the right paddle for a given screen width.
    function automatic int rpad_x_lo(input int h_res);
        return h_res - LPAD_X_LO - PAD_W;
    endfunction

endpackage

// File: rtl/pong_paddle.sv
// pong_paddle: one paddle's top line, moved by a fixed step on
// each enabled frame and clamped to 0..V_RES-PADDLE_H.
// Ports: clk, rst_n (async, active low), step_en (frame move
//   strobe), btn_up, btn_down (both high = no move), pad_y.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int V_RES       = 480,
    parameter int PADDLE_H    = 64,
    parameter int PADDLE_STEP = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step_en,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [8:0] pad_y
);

    localparam logic [8:0] Y_MAX = 9'(V_RES - PADDLE_H);
    localparam logic [8:0] Y_RST = 9'((V_RES - PADDLE_H) / 2);
    localparam logic [8:0] STEP  = 9'(PADDLE_STEP);

    logic [8:0] pad_y_q;
    logic [8:0] pad_y_d;

    always_comb begin
        pad_y_d = pad_y_q;
        if (step_en && (btn_up != btn_down)) begin
            if (btn_up) begin
                pad_y_d = (pad_y_q < STEP) ? '0
                                           : pad_y_q - STEP;
            end else begin
                pad_y_d = (pad_y_q > Y_MAX - STEP) ? Y_MAX
                                                   : pad_y_q + STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_y_q <= Y_RST;
        end else begin
            pad_y_q <= pad_y_d;
        end
    end

    assign pad_y = pad_y_q;

endmodule

// File: rtl/pong_game_state.sv
// pong_game_state: per-frame Pong game core (serve, ball flight,
// paddle hits, scoring, game over). Updates once per frame_tick.
// Ports: clk, rst_n (async, active low), frame_tick, left/right
//   up/down buttons, score_reset, speed_sel; outputs lpad_y,
//   rpad_y, ball_x, ball_y, score_l, score_r, game_over.
// Build option: define PONG_SPEED_SEL_EN to take the ball speed
//   from speed_sel (sampled on entry to play); otherwise 2 px.
module pong_game_state
    import pong_pkg::*;
#(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int PADDLE_H    = 64,
    parameter int PADDLE_STEP = 4,
    parameter int BALL_SIZE   = 8,
    parameter int SCORE_MAX   = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       left_up,
    input  logic       left_down,
    input  logic       right_up,
    input  logic       right_down,
    input  logic       score_reset,
    input  logic [1:0] speed_sel,
    output logic [8:0] lpad_y,
    output logic [8:0] rpad_y,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over
);

    localparam logic [9:0] BX_C = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [8:0] BY_C = 9'((V_RES - BALL_SIZE) / 2);

    localparam logic signed [11:0] X_MAX = 12'(H_RES - BALL_SIZE);
    localparam logic signed [11:0] Y_MAX = 12'(V_RES - BALL_SIZE);
    localparam logic signed [11:0] L_SNAP = 12'(LPAD_X_HI + 1);
    localparam logic signed [11:0] R_SNAP =
        12'(rpad_x_lo(H_RES) - BALL_SIZE);
    localparam logic signed [11:0] PH_S = 12'(PADDLE_H);
    localparam logic signed [11:0] BS_S = 12'(BALL_SIZE);

    localparam logic [FCNT_W-1:0] SERVE_LAST =
        FCNT_W'(SERVE_FRAMES - 1);
    localparam logic [FCNT_W-1:0] POINT_LAST =
        FCNT_W'(POINT_FRAMES - 1);
    localparam logic [3:0] S_MAX = 4'(SCORE_MAX);

    state_e            state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [9:0]        bx_q, bx_d;
    logic [8:0]        by_q, by_d;
    logic              dx_neg_q, dx_neg_d;
    logic              dy_neg_q, dy_neg_d;
    logic [2:0]        spd_q, spd_d;
    logic              srv_r_q, srv_r_d;
    logic [3:0]        sl_q, sl_d;
    logic [3:0]        sr_q, sr_d;
    logic              go_q, go_d;

    logic [2:0]         spd_sel;
    logic               pad_en;
    logic signed [11:0] spd_s, nx, ny_raw, ny;
    logic signed [11:0] lp_s, rp_s;
    logic               dy_neg_b;
    logic               l_ovl, r_ovl;

`ifdef PONG_SPEED_SEL_EN
    assign spd_sel = {1'b0, speed_sel} + 3'd1;
`else
    logic unused_speed_sel;
    assign unused_speed_sel = ^speed_sel;
    assign spd_sel = 3'd2;
`endif

    assign pad_en = frame_tick && (state_q != ST_OVER);

    pong_paddle #(
        .V_RES      (V_RES),
        .PADDLE_H   (PADDLE_H),
        .PADDLE_STEP(PADDLE_STEP)
    ) u_lpad (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_en (pad_en),
        .btn_up  (left_up),
        .btn_down(left_down),
        .pad_y   (lpad_y)
    );

    pong_paddle #(
        .V_RES      (V_RES),
        .PADDLE_H   (PADDLE_H),
        .PADDLE_STEP(PADDLE_STEP)
    ) u_rpad (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_en (pad_en),
        .btn_up  (right_up),
        .btn_down(right_down),
        .pad_y   (rpad_y)
    );

    // Candidate ball position for this frame, vertical bounce folded in.
    assign spd_s  = $signed({9'b0, spd_q});
    assign nx     = $signed({2'b0, bx_q})
                  + (dx_neg_q ? -spd_s : spd_s);
    assign ny_raw = $signed({3'b0, by_q})
                  + (dy_neg_q ? -spd_s : spd_s);

    always_comb begin
        ny       = ny_raw;
        dy_neg_b = dy_neg_q;
        if (ny_raw <= 12'sd0) begin
            ny       = '0;
            dy_neg_b = 1'b0;
        end else if (ny_raw >= Y_MAX) begin
            ny       = Y_MAX;
            dy_neg_b = 1'b1;
        end
    end

    // Hits use the paddle rows as they stood before this frame's move.
    assign lp_s  = $signed({3'b0, lpad_y});
    assign rp_s  = $signed({3'b0, rpad_y});
    assign l_ovl = (ny < lp_s + PH_S) && (lp_s < ny + BS_S);
    assign r_ovl = (ny < rp_s + PH_S) && (rp_s < ny + BS_S);

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        bx_d     = bx_q;
        by_d     = by_q;
        dx_neg_d = dx_neg_q;
        dy_neg_d = dy_neg_q;
        spd_d    = spd_q;
        srv_r_d  = srv_r_q;
        sl_d     = sl_q;
        sr_d     = sr_q;
        if (score_reset) begin
            sl_d    = '0;
            sr_d    = '0;
            state_d = ST_SERVE;
            fcnt_d  = '0;
            bx_d    = BX_C;
            by_d    = BY_C;
        end else if (frame_tick) begin
            unique case (state_q)
                ST_SERVE: begin
                    if (fcnt_q == SERVE_LAST) begin
                        state_d  = ST_PLAY;
                        fcnt_d   = '0;
                        dx_neg_d = !srv_r_q;
                        dy_neg_d = 1'b0;
                        spd_d    = spd_sel;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
                ST_PLAY: begin
                    bx_d     = nx[9:0];
                    by_d     = ny[8:0];
                    dy_neg_d = dy_neg_b;
                    if (dx_neg_q && nx <= L_SNAP && l_ovl) begin
                        bx_d     = L_SNAP[9:0];
                        dx_neg_d = 1'b0;
                    end else if (!dx_neg_q && nx >= R_SNAP
                                 && r_ovl) begin
                        bx_d     = R_SNAP[9:0];
                        dx_neg_d = 1'b1;
                    end else if (dx_neg_q && nx <= 12'sd0) begin
                        bx_d    = '0;
                        sr_d    = sr_q + 4'd1;
                        srv_r_d = 1'b0;
                        state_d = ST_POINT;
                        fcnt_d  = '0;
                    end else if (!dx_neg_q && nx >= X_MAX) begin
                        bx_d    = X_MAX[9:0];
                        sl_d    = sl_q + 4'd1;
                        srv_r_d = 1'b1;
                        state_d = ST_POINT;
                        fcnt_d  = '0;
                    end
                end
                ST_POINT: begin
                    if (fcnt_q == POINT_LAST) begin
                        fcnt_d = '0;
                        if (sl_q == S_MAX || sr_q == S_MAX) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d = ST_SERVE;
                            bx_d    = BX_C;
                            by_d    = BY_C;
                        end
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
                ST_OVER: begin
                    state_d = ST_OVER;
                end
            endcase
        end
        go_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_SERVE;
            fcnt_q   <= '0;
            bx_q     <= BX_C;
            by_q     <= BY_C;
            dx_neg_q <= 1'b0;
            dy_neg_q <= 1'b0;
            spd_q    <= 3'd2;
            srv_r_q  <= 1'b1;
            sl_q     <= '0;
            sr_q     <= '0;
            go_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            dx_neg_q <= dx_neg_d;
            dy_neg_q <= dy_neg_d;
            spd_q    <= spd_d;
            srv_r_q  <= srv_r_d;
            sl_q     <= sl_d;
            sr_q     <= sr_d;
            go_q     <= go_d;
        end
    end

    assign ball_x    = bx_q;
    assign ball_y    = by_q;
    assign score_l   = sl_q;
    assign score_r   = sr_q;
    assign game_over = go_q;

endmodule

// File: tb/tb_pong_game_state.sv
// tb_pong_game_state: randomized and directed bench for
// pong_game_state against a frame-level integer game model.
module tb_pong_game_state;

    localparam int SV = 0;
    localparam int PL = 1;
    localparam int PT = 2;
    localparam int OV = 3;
    localparam int CX = 316;
    localparam int CY = 236;
`ifdef PONG_SPEED_SEL_EN
    localparam int TOP_SPD = 4;
`else
    localparam int TOP_SPD = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       left_up = 1'b0;
    logic       left_down = 1'b0;
    logic       right_up = 1'b0;
    logic       right_down = 1'b0;
    logic       score_reset = 1'b0;
    logic [1:0] speed_sel = 2'd1;
    logic [8:0] lpad_y, rpad_y, ball_y;
    logic [9:0] ball_x;
    logic [3:0] score_l, score_r;
    logic       game_over;
    logic [45:0] obs;

    int n_checks = 0;
    int n_fail = 0;

    int m_st, m_cnt, m_bx, m_by, m_dx, m_dy;
    int m_lp, m_rp, m_sl, m_sr;
    bit m_srv_r, m_top;

    always #5 clk = ~clk;

    pong_game_state dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .left_up    (left_up),
        .left_down  (left_down),
        .right_up   (right_up),
        .right_down (right_down),
        .score_reset(score_reset),
        .speed_sel  (speed_sel),
        .lpad_y     (lpad_y),
        .rpad_y     (rpad_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_over  (game_over)
    );

    assign obs = {lpad_y, rpad_y, ball_x, ball_y,
                  score_l, score_r, game_over};

    function automatic logic [45:0] mvec();
        return {9'(m_lp), 9'(m_rp), 10'(m_bx), 9'(m_by),
                4'(m_sl), 4'(m_sr), (m_st == OV)};
    endfunction

    function automatic int pad_next(int y, bit up, bit dn);
        if (up && !dn) return (y - 4 < 0) ? 0 : y - 4;
        if (dn && !up) return (y + 4 > 416) ? 416 : y + 4;
        return y;
    endfunction

    function automatic bit overlaps(int by, int py);
        return (by < py + 64) && (py < by + 8);
    endfunction

    function automatic int speed_now();
`ifdef PONG_SPEED_SEL_EN
        return int'(speed_sel) + 1;
`else
        return 2;
`endif
    endfunction

    task automatic model_reset();
        m_st = SV; m_cnt = 0; m_bx = CX; m_by = CY;
        m_dx = 2; m_dy = 2; m_lp = 208; m_rp = 208;
        m_sl = 0; m_sr = 0; m_srv_r = 1; m_top = 0;
    endtask

    task automatic model_step(input bit tick, input bit srst,
            input bit lu, input bit ld, input bit ru, input bit rd);
        int nx, ny, lp0, rp0, s;
        lp0 = m_lp;
        rp0 = m_rp;
        m_top = 0;
        if (tick && m_st != OV) begin
            m_lp = pad_next(m_lp, lu, ld);
            m_rp = pad_next(m_rp, ru, rd);
        end
        if (srst) begin
            m_sl = 0; m_sr = 0; m_st = SV; m_cnt = 0;
            m_bx = CX; m_by = CY;
        end else if (tick) begin
            case (m_st)
                SV: begin
                    m_cnt++;
                    if (m_cnt == 60) begin
                        m_st = PL; m_cnt = 0;
                        s = speed_now();
                        m_dx = m_srv_r ? s : -s;
                        m_dy = s;
                    end
                end
                PL: begin
                    nx = m_bx + m_dx;
                    ny = m_by + m_dy;
                    if (ny <= 0) begin
                        ny = 0; m_dy = (m_dy < 0) ? -m_dy : m_dy;
                        m_top = 1;
                    end else if (ny >= 472) begin
                        ny = 472; m_dy = (m_dy > 0) ? -m_dy : m_dy;
                    end
                    if (m_dx < 0 && nx <= 24 && overlaps(ny, lp0)) begin
                        nx = 24; m_dx = -m_dx;
                    end else if (m_dx > 0 && nx + 7 >= 615
                                 && overlaps(ny, rp0)) begin
                        nx = 608; m_dx = -m_dx;
                    end else if (m_dx < 0 && nx <= 0) begin
                        nx = 0; m_sr++; m_srv_r = 0;
                        m_st = PT; m_cnt = 0;
                    end else if (m_dx > 0 && nx >= 632) begin
                        nx = 632; m_sl++; m_srv_r = 1;
                        m_st = PT; m_cnt = 0;
                    end
                    m_bx = nx;
                    m_by = ny;
                end
                PT: begin
                    m_cnt++;
                    if (m_cnt == 30) begin
                        m_cnt = 0;
                        if (m_sl == 9 || m_sr == 9) begin
                            m_st = OV;
                        end else begin
                            m_st = SV; m_bx = CX; m_by = CY;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic drive(input bit tick, input bit srst,
            input bit lu, input bit ld, input bit ru, input bit rd);
        frame_tick = tick; score_reset = srst;
        left_up = lu; left_down = ld;
        right_up = ru; right_down = rd;
        model_step(tick, srst, lu, ld, ru, rd);
        @(negedge clk);
        frame_tick = 1'b0;
        score_reset = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; frame_tick = 1'b0; score_reset = 1'b0;
        left_up = 1'b0; left_down = 1'b0;
        right_up = 1'b0; right_down = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs !== mvec()) begin
            n_fail++;
            $display("FAIL reset_vec got %h exp %h", obs, mvec());
        end
        n_checks++;
        if (lpad_y !== 9'd208 || rpad_y !== 9'd208
            || ball_x !== 10'd316 || ball_y !== 9'd236) begin
            n_fail++;
            $display("FAIL reset_pos got %0d %0d %0d %0d exp 208 208 316 236",
                     lpad_y, rpad_y, ball_x, ball_y);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_serve_to_play();
        apply_reset();
        for (int k = 1; k <= 60; k++) begin
            drive(1, 0, 0, 0, 0, 0);
            n_checks++;
            if (obs !== mvec()) begin
                n_fail++;
                $display("FAIL serve f%0d got %h exp %h", k, obs, mvec());
            end
        end
        n_checks++;
        if (ball_x !== 10'd316 || ball_y !== 9'd236) begin
            n_fail++;
            $display("FAIL serve_hold got %0d,%0d exp 316,236",
                     ball_x, ball_y);
        end
        left_up = 1'b1;
        repeat (3) @(negedge clk);
        left_up = 1'b0;
        n_checks++;
        if (lpad_y !== 9'd208 || ball_x !== 10'd316) begin
            n_fail++;
            $display("FAIL no_tick_hold got %0d,%0d exp 208,316",
                     lpad_y, ball_x);
        end
        drive(1, 0, 0, 0, 0, 0);
        n_checks++;
        if (ball_x !== 10'd318 || ball_y !== 9'd238) begin
            n_fail++;
            $display("FAIL first_move got %0d,%0d exp 318,238",
                     ball_x, ball_y);
        end
    endtask

    task automatic test_paddle_up_clamp();
        int exp_y;
        apply_reset();
        for (int k = 1; k <= 100; k++) begin
            drive(1, 0, 1, 0, 0, 0);
            exp_y = (208 - 4 * k < 0) ? 0 : 208 - 4 * k;
            n_checks++;
            if (lpad_y !== 9'(exp_y) || obs !== mvec()) begin
                n_fail++;
                $display("FAIL pad_up f%0d got %0d exp %0d", k, lpad_y, exp_y);
            end
        end
    endtask

    task automatic test_paddle_both();
        for (int k = 1; k <= 5; k++) drive(1, 0, 0, 1, 0, 1);
        for (int k = 1; k <= 10; k++) begin
            drive(1, 0, 1, 1, 1, 1);
            n_checks++;
            if (lpad_y !== 9'd20 || obs !== mvec()) begin
                n_fail++;
                $display("FAIL pad_both f%0d got %0d exp 20", k, lpad_y);
            end
        end
    endtask

    task automatic test_point_right();
        int k;
        apply_reset();
        k = 0;
        while (m_st != PT && k < 400) begin
            drive(1, 0, 0, 0, 1, 0);
            k++;
            n_checks++;
            if (obs !== mvec()) begin
                n_fail++;
                $display("FAIL to_point f%0d got %h exp %h", k, obs, mvec());
            end
        end
        n_checks++;
        if (m_st != PT || ball_x !== 10'd632 || score_l !== 4'd1
            || score_r !== 4'd0) begin
            n_fail++;
            $display("FAIL point_edge got x%0d l%0d r%0d exp x632 l1 r0",
                     ball_x, score_l, score_r);
        end
        for (int f = 1; f <= 30; f++) begin
            drive(1, 0, 0, 0, 1, 0);
            n_checks++;
            if (ball_x !== ((f < 30) ? 10'd632 : 10'd316)
                || obs !== mvec()) begin
                n_fail++;
                $display("FAIL point_hold f%0d got x%0d", f, ball_x);
            end
        end
        for (int f = 1; f <= 61; f++) drive(1, 0, 0, 0, 1, 0);
        n_checks++;
        if (ball_x !== 10'd318 || obs !== mvec()) begin
            n_fail++;
            $display("FAIL serve_right got x%0d exp 318", ball_x);
        end
    endtask

    task automatic test_game_over();
        logic [45:0] frozen;
        int k;
        k = 0;
        while (m_st != OV && k < 3000) begin
            drive(1, 0, 0, 0, 1, 0);
            k++;
            n_checks++;
            if (obs !== mvec()) begin
                n_fail++;
                $display("FAIL to_over f%0d got %h exp %h", k, obs, mvec());
            end
        end
        n_checks++;
        if (game_over !== 1'b1 || score_l !== 4'd9) begin
            n_fail++;
            $display("FAIL game_over got go%0d l%0d exp go1 l9",
                     game_over, score_l);
        end
        frozen = obs;
        for (int f = 1; f <= 5; f++) begin
            drive(1, 0, 0, 1, 0, 1);
            n_checks++;
            if (obs !== frozen || obs !== mvec()) begin
                n_fail++;
                $display("FAIL over_frozen f%0d got %h exp %h", f, obs, frozen);
            end
        end
        drive(0, 1, 0, 0, 0, 0);
        n_checks++;
        if (score_l !== 4'd0 || score_r !== 4'd0 || game_over !== 1'b0
            || ball_x !== 10'd316 || obs !== mvec()) begin
            n_fail++;
            $display("FAIL score_reset got l%0d r%0d go%0d x%0d exp 0 0 0 316",
                     score_l, score_r, game_over, ball_x);
        end
    endtask

    task automatic test_top_bounce();
        int k;
        bit lu, ld, ru, rd;
        apply_reset();
        speed_sel = 2'd3;
        k = 0;
        while (!m_top && k < 700) begin
            lu = (m_lp + 32 > m_by + 4);
            ld = (m_lp + 32 < m_by + 4);
            ru = (m_rp + 32 > m_by + 4);
            rd = (m_rp + 32 < m_by + 4);
            drive(1, 0, lu, ld, ru, rd);
            k++;
            n_checks++;
            if (obs !== mvec()) begin
                n_fail++;
                $display("FAIL to_top f%0d got %h exp %h", k, obs, mvec());
            end
        end
        n_checks++;
        if (!m_top || ball_y !== 9'd0) begin
            n_fail++;
            $display("FAIL top_clamp got y%0d exp 0", ball_y);
        end
        drive(1, 0, 0, 0, 0, 0);
        n_checks++;
        if (ball_y !== 9'(TOP_SPD) || obs !== mvec()) begin
            n_fail++;
            $display("FAIL top_bounce got y%0d exp %0d", ball_y, TOP_SPD);
        end
        speed_sel = 2'd1;
    endtask

    task automatic test_midgame_reset();
        apply_reset();
        for (int k = 0; k < 80; k++) begin
            drive(1, 0, 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs !== mvec()) begin
            n_fail++;
            $display("FAIL async_reset got %h exp %h", obs, mvec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 61; k++) begin
            drive(1, 0, 0, 0, 0, 0);
            n_checks++;
            if (obs !== mvec()
                || (k == 60 && ball_x !== 10'd316)
                || (k == 61 && ball_x !== 10'd318)) begin
                n_fail++;
                $display("FAIL after_reset f%0d got %h exp %h",
                         k, obs, mvec());
            end
        end
    endtask

    task automatic test_random();
        bit tick, srst;
        apply_reset();
        for (int k = 1; k <= 1500; k++) begin
            speed_sel = 2'($urandom_range(0, 3));
            tick = ($urandom_range(0, 7) != 0);
            srst = ($urandom_range(0, 299) == 0);
            drive(tick, srst, 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
            n_checks++;
            if (obs !== mvec()) begin
                n_fail++;
                $display("FAIL random f%0d got %h exp %h", k, obs, mvec());
            end
        end
        speed_sel = 2'd1;
    endtask

    initial begin
        test_reset();
        test_serve_to_play();
        test_paddle_up_clamp();
        test_paddle_both();
        test_point_right();
        test_game_over();
        test_top_bounce();
        test_midgame_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
